// File: rtl/host_ctrl_pkg.sv
// Shared encodings for the host controller: command codes, controller states
// (also the status readback value) and readback region selects.
package host_ctrl_pkg;

    localparam logic [1:0] CMD_HALT   = 2'b00;
    localparam logic [1:0] CMD_LOAD_I = 2'b01;
    localparam logic [1:0] CMD_LOAD_D = 2'b10;
    localparam logic [1:0] CMD_RUN    = 2'b11;

    // State codes double as the status readback word, so keep them fixed.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    localparam logic [1:0] RB_DCACHE = 2'b00;
    localparam logic [1:0] RB_REG    = 2'b01;
    localparam logic [1:0] RB_CYCLE  = 2'b10;
    localparam logic [1:0] RB_STATUS = 2'b11;

    typedef struct packed {
        logic [1:0]  region;
        logic [31:0] reg_data;
        logic [31:0] cycle_snap;
        logic [2:0]  state;
    } rb_capture_t;

    function automatic logic [31:0] status_word(input logic [2:0] st);
        return {29'b0, st};
    endfunction

endpackage

// File: rtl/host_readback.sv
// Two-stage readback: capture select and sideband values, then merge with the
// one-cycle-late D_Cache read data into the registered data_out.
module host_readback
    import host_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rb_sel,
    input  logic [31:0] reg_data,
    input  logic [31:0] cycle_snap,
    input  logic [2:0]  state,
    input  logic [31:0] dcache_data,
    output logic [31:0] data_out
);

    rb_capture_t capture_q;
    logic [31:0] rb_mux;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capture_q <= '0;
        end else begin
            capture_q.region     <= rb_sel;
            capture_q.reg_data   <= reg_data;
            capture_q.cycle_snap <= cycle_snap;
            capture_q.state      <= state;
        end
    end

    // D_Cache data arrives here, aligned with the captured select.
    always_comb begin
        rb_mux = dcache_data;
        case (capture_q.region)
            RB_DCACHE: rb_mux = dcache_data;
            RB_REG:    rb_mux = capture_q.reg_data;
            RB_CYCLE:  rb_mux = capture_q.cycle_snap;
            RB_STATUS: rb_mux = status_word(capture_q.state);
            default:   rb_mux = dcache_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= rb_mux;
        end
    end

endmodule

// File: rtl/host_ctrl.sv
// Host-side controller: sequences the core through idle, load, run and drain,
// gates cache writes to the load phase and feeds the readback path.
module host_ctrl
    import host_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cmd,
    input  logic        host_valid,
    input  logic [31:0] addr_in,
    input  logic [31:0] reg_data_e,
    input  logic [31:0] D_Cache_data_e,
    output logic        host_ready,
    output logic        I_Cache_wen_e,
    output logic [3:0]  D_Cache_wen_e,
    output logic        cpu_run,
    output logic        fetch_hold,
    output logic        pipe_flush,
    output logic [31:0] data_out
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [DRN_W-1:0] drain_cnt;
    logic [CNT_W-1:0] cycle_cnt;
    logic [31:0]      cycle_snap;
    logic             load_wr;
    logic             run_exit;
    logic             unused_addr_bits;

    assign run_exit = (state == ST_RUN) && (cmd != CMD_RUN);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd == CMD_LOAD_I || cmd == CMD_LOAD_D) begin
                    state_nxt = ST_LOAD;
                end else if (cmd == CMD_RUN) begin
                    state_nxt = ST_START;
                end
            end
            ST_LOAD: begin
                if (cmd == CMD_HALT) begin
                    state_nxt = ST_IDLE;
                end else if (cmd == CMD_RUN) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: state_nxt = ST_RUN;
            ST_RUN: begin
                if (cmd != CMD_RUN) begin
                    state_nxt = ST_DRAIN;
                end
            end
            // A RUN request during drain is only honoured once back in IDLE.
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if (run_exit) begin
            drain_cnt <= DRN_W'(DRAIN_CYCLES - 1);
        end else if (state == ST_DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DRN_W'(1);
        end
    end

    // Counts RUN cycles only and sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (state == ST_START) begin
            cycle_cnt <= '0;
        end else if (state == ST_RUN && cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    assign host_ready = (state == ST_LOAD);
    assign cpu_run    = (state == ST_RUN) || (state == ST_DRAIN);
    assign fetch_hold = (state == ST_DRAIN);
    assign pipe_flush = (state == ST_START);

    assign load_wr       = (state == ST_LOAD) && host_valid;
    assign I_Cache_wen_e = load_wr && (cmd == CMD_LOAD_I);
    assign D_Cache_wen_e = {4{load_wr && (cmd == CMD_LOAD_D)}};

    assign cycle_snap = 32'(cycle_cnt);

    // Low address bits go straight to the caches and register file outside.
    assign unused_addr_bits = ^addr_in[29:0];

    host_readback u_readback (
        .clk         (clk),
        .reset       (reset),
        .rb_sel      (addr_in[31:30]),
        .reg_data    (reg_data_e),
        .cycle_snap  (cycle_snap),
        .state       (state),
        .dcache_data (D_Cache_data_e),
        .data_out    (data_out)
    );

endmodule

// File: tb/tb_host_ctrl.sv
// Self-checking bench for host_ctrl: directed scenarios followed by random
// command traffic, all compared against a phase-level reference model.
module tb_host_ctrl;

    localparam int    DRAIN_CYCLES = 4;
    localparam int    CNT_W        = 32;
    localparam longint CNT_MAX     = (longint'(1) << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cmd;
    logic        host_valid;
    logic [31:0] addr_in;
    logic [31:0] reg_data_e;
    logic [31:0] D_Cache_data_e = 32'h0;
    logic        host_ready;
    logic        I_Cache_wen_e;
    logic [3:0]  D_Cache_wen_e;
    logic        cpu_run;
    logic        fetch_hold;
    logic        pipe_flush;
    logic [31:0] data_out;

    logic [31:0] regs [32];
    logic [31:0] dmem [16];

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase 0..4 = idle, load, start, run, drain
    int          m_phase;
    longint      m_cnt;
    int          m_drain_left;
    logic [1:0]  cap_region;
    logic [31:0] cap_reg;
    logic [31:0] cap_cnt;
    int          cap_phase;
    logic [31:0] m_dout;

    host_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd),
        .host_valid     (host_valid),
        .addr_in        (addr_in),
        .reg_data_e     (reg_data_e),
        .D_Cache_data_e (D_Cache_data_e),
        .host_ready     (host_ready),
        .I_Cache_wen_e  (I_Cache_wen_e),
        .D_Cache_wen_e  (D_Cache_wen_e),
        .cpu_run        (cpu_run),
        .fetch_hold     (fetch_hold),
        .pipe_flush     (pipe_flush),
        .data_out       (data_out)
    );

    always #5 clk = ~clk;

    assign reg_data_e = regs[addr_in[4:0]];

    always @(posedge clk) D_Cache_data_e <= dmem[addr_in[5:2]];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_phase      = 0;
        m_cnt        = 0;
        m_drain_left = 0;
        cap_region   = 2'b00;
        cap_reg      = 32'h0;
        cap_cnt      = 32'h0;
        cap_phase    = 0;
        m_dout       = 32'h0;
    endtask

    task automatic modelStep(input logic [1:0] c, input logic [31:0] a,
                             input logic [31:0] r, input logic [31:0] d);
        case (cap_region)
            2'b00:   m_dout = d;
            2'b01:   m_dout = cap_reg;
            2'b10:   m_dout = cap_cnt;
            default: m_dout = 32'(cap_phase);
        endcase
        cap_region = a[31:30];
        cap_reg    = r;
        cap_cnt    = m_cnt[31:0];
        cap_phase  = m_phase;
        case (m_phase)
            0: begin
                if (c == 2'b01 || c == 2'b10) m_phase = 1;
                else if (c == 2'b11)          m_phase = 2;
            end
            1: begin
                if (c == 2'b00)      m_phase = 0;
                else if (c == 2'b11) m_phase = 2;
            end
            2: begin
                m_cnt   = 0;
                m_phase = 3;
            end
            3: begin
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                if (c != 2'b11) begin
                    m_phase      = 4;
                    m_drain_left = DRAIN_CYCLES;
                end
            end
            default: begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_phase = 0;
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic v, input logic [31:0] a);
        bit wr;
        cmd        = c;
        host_valid = v;
        addr_in    = a;
        #1;
        wr = (m_phase == 1) && v;
        checkOutput("host_ready", 32'(host_ready), 32'(m_phase == 1));
        checkOutput("cpu_run",    32'(cpu_run),    32'(m_phase == 3 || m_phase == 4));
        checkOutput("fetch_hold", 32'(fetch_hold), 32'(m_phase == 4));
        checkOutput("pipe_flush", 32'(pipe_flush), 32'(m_phase == 2));
        checkOutput("i_wen",      32'(I_Cache_wen_e), 32'(wr && c == 2'b01));
        checkOutput("d_wen",      32'(D_Cache_wen_e), (wr && c == 2'b10) ? 32'hF : 32'h0);
        checkOutput("data_out",   data_out, m_dout);
    endtask

    task automatic tick();
        logic [1:0]  c_s;
        logic [31:0] a_s, r_s, d_s;
        c_s = cmd;
        a_s = addr_in;
        r_s = reg_data_e;
        d_s = D_Cache_data_e;
        @(posedge clk);
        if (!reset) modelStep(c_s, a_s, r_s, d_s);
        @(negedge clk);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_ready", 32'(host_ready),    32'h0);
        checkOutput("rst_iwen",  32'(I_Cache_wen_e), 32'h0);
        checkOutput("rst_dwen",  32'(D_Cache_wen_e), 32'h0);
        checkOutput("rst_run",   32'(cpu_run),       32'h0);
        checkOutput("rst_hold",  32'(fetch_hold),    32'h0);
        checkOutput("rst_flush", 32'(pipe_flush),    32'h0);
        checkOutput("rst_dout",  data_out,           32'h0);
        modelReset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int       hold_left;
        logic [1:0] rc;

        reset      = 1'b1;
        cmd        = 2'b00;
        host_valid = 1'b0;
        addr_in    = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 16; i++) dmem[i] = $urandom;
        regs[5] = 32'hDEADBEEF;
        dmem[4] = 32'h12345678;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_dout",  data_out,         32'h0);
        checkOutput("reset_ready", 32'(host_ready),  32'h0);
        checkOutput("reset_run",   32'(cpu_run),     32'h0);
        reset = 1'b0;

        $display("[TB] load I-side");
        applyStimulus(2'b01, 1'b1, 32'h100);
        checkOutput("t1_iwen_idle", 32'(I_Cache_wen_e), 32'h0);
        tick();
        applyStimulus(2'b01, 1'b1, 32'h104);
        checkOutput("t1_ready", 32'(host_ready),    32'h1);
        checkOutput("t1_iwen",  32'(I_Cache_wen_e), 32'h1);
        checkOutput("t1_dwen",  32'(D_Cache_wen_e), 32'h0);
        tick();

        $display("[TB] load D-side with valid toggling");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, (i != 1), 32'h200 + 32'(4 * i));
            checkOutput("t2_dwen", 32'(D_Cache_wen_e), (i != 1) ? 32'hF : 32'h0);
            tick();
        end
        applyStimulus(2'b00, 1'b0, 32'h0);
        tick();
        applyStimulus(2'b10, 1'b1, 32'h0);
        checkOutput("t2_idle_drop", 32'(D_Cache_wen_e), 32'h0);
        applyStimulus(2'b00, 1'b0, 32'h0);
        tick();

        $display("[TB] run 100 cycles then drain");
        applyStimulus(2'b11, 1'b0, 32'h0);
        tick();
        applyStimulus(2'b11, 1'b0, 32'h0);
        checkOutput("t3_flush",    32'(pipe_flush), 32'h1);
        checkOutput("t3_run_low",  32'(cpu_run),    32'h0);
        tick();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(2'b11, 1'b0, 32'h0);
            if (i == 0) begin
                checkOutput("t3_flush_off", 32'(pipe_flush), 32'h0);
                checkOutput("t3_run_high",  32'(cpu_run),    32'h1);
            end
            tick();
        end
        applyStimulus(2'b00, 1'b0, 32'h80000000);
        tick();
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            applyStimulus(2'b11, 1'b0, (i == 1) ? 32'hC0000000 : 32'h0);
            checkOutput("t4_hold", 32'(fetch_hold), 32'h1);
            checkOutput("t4_run",  32'(cpu_run),    32'h1);
            tick();
            if (i == 0) checkOutput("t3_cycles", data_out, 32'd100);
            if (i == 2) checkOutput("t4_status_drain", data_out, 32'd4);
        end
        applyStimulus(2'b00, 1'b0, 32'hC0000000);
        checkOutput("t4_run_off",  32'(cpu_run),    32'h0);
        checkOutput("t4_hold_off", 32'(fetch_hold), 32'h0);
        tick();
        applyStimulus(2'b00, 1'b0, 32'h0);
        tick();
        checkOutput("t4_status_idle", data_out, 32'd0);

        $display("[TB] register and D_Cache readback");
        applyStimulus(2'b00, 1'b0, 32'h40000005);
        tick();
        applyStimulus(2'b00, 1'b0, 32'h0);
        tick();
        checkOutput("t5_reg", data_out, 32'hDEADBEEF);
        applyStimulus(2'b00, 1'b0, 32'h00000010);
        tick();
        applyStimulus(2'b00, 1'b0, 32'h40000000);
        tick();
        checkOutput("t5_dcache", data_out, 32'h12345678);

        $display("[TB] reset mid-drain and mid-load");
        applyStimulus(2'b11, 1'b0, 32'h0);
        tick();
        applyStimulus(2'b11, 1'b0, 32'h0);
        tick();
        applyStimulus(2'b00, 1'b0, 32'h0);
        tick();
        applyStimulus(2'b00, 1'b0, 32'h0);
        checkOutput("t6_in_drain", 32'(fetch_hold), 32'h1);
        doReset();
        applyStimulus(2'b01, 1'b1, 32'h0);
        tick();
        applyStimulus(2'b01, 1'b1, 32'h4);
        checkOutput("t6_in_load", 32'(I_Cache_wen_e), 32'h1);
        doReset();
        applyStimulus(2'b01, 1'b1, 32'h8);
        tick();
        applyStimulus(2'b01, 1'b1, 32'hC);
        checkOutput("t6_resume_ready", 32'(host_ready),    32'h1);
        checkOutput("t6_resume_iwen",  32'(I_Cache_wen_e), 32'h1);
        tick();

        $display("[TB] random traffic");
        hold_left = 0;
        rc        = 2'b00;
        for (int n = 0; n < 2000; n++) begin
            if (hold_left == 0) begin
                rc        = 2'($urandom_range(0, 3));
                hold_left = (rc == 2'b11) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 8));
            end
            hold_left--;
            applyStimulus(rc, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 299) == 0) doReset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/host_ctrl.md
# host_ctrl

Host-side controller for the five-stage RISC-V core. It decodes the external `cmd` bus and sequences the core through four phases: idle, program/data load, run, and pipeline drain. It produces the I_Cache and D_Cache external write enables, the pipeline run, hold and flush controls, and a registered readback path that drives `data_out`. It sits between the top-level host pins and the core datapath, so that memory loading and readback never overlap execution.

## Interface
Parameters:
- `DRAIN_CYCLES`, 4: cycles of fetch hold after leaving RUN, before the pipeline is frozen. Must be ≥1.
- `CNT_W`, 32: width of the run-cycle counter. Must be ≤32.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state and outputs clear immediately.
- `cmd`  in  2  host command: 00 HALT, 01 LOAD_I, 10 LOAD_D, 11 RUN.
- `host_valid`  in  1  host write strobe, qualified by `host_ready`.
- `addr_in`  in  32  host address. [31:30] selects the readback region.
- `reg_data_e`  in  32  register-file external read data (combinational).
- `D_Cache_data_e`  in  32  D_Cache port-b read data (1-cycle synchronous).
- `host_ready`  out  1  high only in LOAD.
- `I_Cache_wen_e`  out  1  I_Cache port-a write enable.
- `D_Cache_wen_e`  out  4  D_Cache port-b byte write enables.
- `cpu_run`  out  1  pipeline advance enable; low freezes every stage.
- `fetch_hold`  out  1  freeze PC and inject bubbles into IF/ID.
- `pipe_flush`  out  1  one-cycle clear of all pipeline registers.
- `data_out`  out  32  registered readback.

## Operation
- State set: IDLE, LOAD, START, RUN, DRAIN. Reset state is IDLE.
- IDLE transitions:
  - `cmd`=01 or 10 → LOAD.
  - `cmd`=11 → START.
  - `cmd`=00 → stay in IDLE.
- LOAD transitions:
  - `cmd`=00 → IDLE.
  - `cmd`=11 → START.
  - `cmd`=01 or 10 → stay; switching between them is allowed without leaving LOAD.
- START:
  - `pipe_flush`=1, `cpu_run`=0, cycle counter cleared.
  - Always → RUN on the next cycle.
- RUN:
  - `cpu_run`=1; cycle counter increments and saturates at all-ones.
  - `cmd`≠11 → DRAIN, with the drain counter loaded to `DRAIN_CYCLES`-1.
- DRAIN:
  - `cpu_run`=1, `fetch_hold`=1; drain counter decrements.
  - At 0 → IDLE.
  - `cmd` is ignored; a RUN request is re-evaluated from IDLE.
- Write enables (combinational, same-cycle with `addr_in`/data):
  - `I_Cache_wen_e` = LOAD & `host_valid` & `cmd`==01.
  - `D_Cache_wen_e` = {4{LOAD & `host_valid` & `cmd`==10}}.
  - Writes outside LOAD are dropped silently.
- `host_ready`, `cpu_run`, `fetch_hold` and `pipe_flush` are decoded from the state register only. They must not depend combinationally on `cmd`.
- Readback regions, selected by `addr_in[31:30]`:
  - 00: D_Cache word.
  - 01: register `addr_in[4:0]`.
  - 10: cycle counter, zero-extended.
  - 11: status = {29'b0, state[2:0]}, with encoding IDLE=0, LOAD=1, START=2, RUN=3, DRAIN=4.
- Readback is active in every state. In RUN, D_Cache/register values reflect in-flight contents and are not guaranteed coherent.

## Timing
- Reset values: `data_out`=0, counters=0; all control outputs 0.
- A `cmd` change is sampled at the edge; the resulting state is visible on the next cycle.
- Minimum transition latencies:
  - The first accepted write occurs one cycle after LOAD_I/LOAD_D is presented.
  - RUN: START lasts exactly 1 cycle, then `cpu_run` rises.
  - Leaving RUN: `cpu_run` stays high for exactly `DRAIN_CYCLES` cycles with `fetch_hold`=1, then drops.
- Readback pipeline, total latency 2 cycles for every region:
  - Edge of cycle t: capture the region select, `reg_data_e`, the counter snapshot and the state.
  - Cycle t+1: mux against `D_Cache_data_e`.
  - `data_out` is updated at the end of t+1 and is valid from t+2.
- Cycle counter: counts cycles spent in RUN only; it holds its value in DRAIN and IDLE.
- An asynchronous reset asserted in any state returns to IDLE within the same cycle and cancels a pending drain or write.

## Structure
- A shared package holds:
  - The `cmd` encodings (CMD_HALT/LOAD_I/LOAD_D/RUN).
  - The state enumeration and its status encoding.
  - The readback region codes.
- One sub-module, `host_readback`: the 2-stage capture/mux register feeding `data_out`. The FSM, drain counter and cycle counter stay in `host_ctrl`.

## Test plan
- Reset then `cmd`=01 with `host_valid`=1 → the cycle after `cmd` is presented, `host_ready`=1 and `I_Cache_wen_e`=1; the D-side enable stays 0.
- LOAD_D with `host_valid` toggling 1,0,1 → `D_Cache_wen_e`=1111,0000,1111; the enable is never asserted while `host_ready`=0.
- IDLE, `cmd`=11 → `pipe_flush` high for exactly one cycle, then `cpu_run`=1; after 100 RUN cycles, a readback at `addr_in`=0x80000000 returns 100 two cycles later.
- In RUN, `cmd`=00 with `DRAIN_CYCLES`=4 → `fetch_hold`=1 and `cpu_run`=1 for 4 cycles, then both 0 and status readback = 0; `cmd`=11 during DRAIN has no effect until IDLE.
- Readback of `addr_in`=0x40000005 with `reg_data_e`=0xDEADBEEF → `data_out`=0xDEADBEEF after 2 cycles; `addr_in`=0x00000010 with `D_Cache_data_e` returning 0x12345678 → the same 2-cycle latency.
- Reset asserted mid-DRAIN and mid-LOAD → all outputs 0 immediately and state returns to IDLE; after release, `cmd`=01 resumes LOAD normally.
